// File: rtl/spi_adc_reader.sv
// spi_adc_reader
//   SPI master that reads one frame from a serial ADC per start request.
//   A frame is LEAD+WIDTH sclk periods long. The leading LEAD bits are
//   discarded and the trailing WIDTH bits become the sample, MSB first.
//   The sample is offered to a consumer through a valid/ready handshake.
//
// Parameters
//   WIDTH  sample bits kept per frame (>= 1)
//   LEAD   leading frame bits discarded (>= 0)
//   DIV    clk cycles per sclk half-period (>= 1)
//
// Ports
//   clk      in   system clock, rising edge
//   clr_n    in   asynchronous active-low reset
//   start    in   request a conversion frame (honoured only when idle)
//   miso     in   ADC serial data, MSB first
//   sclk     out  SPI clock, idles low
//   cs_n     out  ADC chip select, active-low
//   sample   out  last captured sample
//   valid    out  sample holds unconsumed data
//   ready    in   consumer takes sample when valid & ready
//   busy     out  a frame (including setup/hold) is in progress
//   overrun  out  sticky flag: a sample was overwritten before being read
//
// Build option
//   SPI_ADC_READER_OVERRUN_EN  defined: overrun flag logic is built.
//                              undefined: overrun is tied to 0.

module spi_adc_reader #(
    parameter int WIDTH = 12,
    parameter int LEAD  = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             miso,
    output logic             sclk,
    output logic             cs_n,
    output logic [WIDTH-1:0] sample,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             overrun
);

    localparam int N  = LEAD + WIDTH;
    localparam int CW = $clog2(DIV + 1);
    localparam int BW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_sclk_next;
    logic             w_cs_n_next;
    logic             w_half_end;
    logic             w_rise;
    logic             w_load;

    // r_cnt counts clk cycles inside the current DIV-cycle interval
    // (setup, each sclk half-period, hold).
    assign w_half_end = (r_cnt == CNT_LAST);

    // sclk is about to go 0->1: this is the miso sampling edge.
    assign w_rise = (r_state == S_SHIFT) && w_half_end && !sclk;

    // End of the high half of the last sclk period: frame complete.
    assign w_load = (r_state == S_SHIFT) && w_half_end && sclk && (r_bit == BIT_LAST);

    assign busy = (r_state != S_IDLE);

    // Only the last WIDTH bits shifted in are ever observable, so the
    // register is WIDTH wide and the LEAD bits simply fall off the top.
    generate
        if (WIDTH == 1) begin : g_sh1
            assign w_shift_next = miso;
        end else begin : g_shn
            assign w_shift_next = {r_shreg[WIDTH-2:0], miso};
        end
    endgenerate

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            sclk    <= w_sclk_next;
            cs_n    <= w_cs_n_next;
        end
    end

    // sclk and cs_n next values are decided here but only ever leave the
    // block through the flops above, so the pins cannot glitch.
    always_comb begin
        w_state_next = r_state;
        w_sclk_next  = sclk;
        w_cs_n_next  = cs_n;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SETUP;
                    w_cs_n_next  = 1'b0;
                end
            end
            S_SETUP: begin
                if (w_half_end) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_half_end) begin
                    w_sclk_next = !sclk;
                end
                if (w_load) begin
                    w_state_next = S_HOLD;
                    w_sclk_next  = 1'b0;
                    w_cs_n_next  = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_half_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_sclk_next  = 1'b0;
                w_cs_n_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            sample  <= '0;
            valid   <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_half_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_load) begin
                r_bit <= '0;
            end else if (r_state == S_SHIFT && w_half_end && sclk) begin
                r_bit <= r_bit + 1'b1;
            end

            if (w_rise) begin
                r_shreg <= w_shift_next;
            end

            // A load wins over a simultaneous consume: the new sample
            // stays pending.
            if (w_load) begin
                sample <= r_shreg;
                valid  <= 1'b1;
            end else if (ready) begin
                valid  <= 1'b0;
            end
        end
    end

`ifdef SPI_ADC_READER_OVERRUN_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            overrun <= 1'b0;
        end else if (w_load && valid && !ready) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_adc_reader.sv
module tb_spi_adc_reader;

    localparam int DA = 2;
    localparam int NA = 16;
    localparam int LA = DA + 2 * DA * NA;      // edges from E0 to sample load
    localparam int KA = 2 * DA + 2 * DA * NA;  // edges from E0 to busy low
`ifdef SPI_ADC_READER_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;

    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        miso;
    logic        sclk;
    logic        cs_n;
    logic [11:0] sample;
    logic        valid;
    logic        busy;
    logic        overrun;

    logic        start_b = 1'b0;
    logic        ready_b = 1'b1;
    logic        miso_b = 1'b1;
    logic        sclk_b;
    logic        cs_n_b;
    logic [0:0]  sample_b;
    logic        valid_b;
    logic        busy_b;
    logic        overrun_b;

    int checks = 0;
    int errors = 0;

    // ADC model: presents frame bit (15 - bk) on miso, advancing after
    // each falling sclk edge of the frame.
    logic [15:0] adc_word = 16'h0;
    int          bk = 0;
    always @(negedge cs_n) bk = 0;
    always @(negedge sclk) bk = bk + 1;
    assign miso = (bk < 16) ? adc_word[15 - bk] : 1'b0;

    // Reference model state: pending sample and sticky overrun.
    logic m_pend = 1'b0;
    logic m_ovr  = 1'b0;

    always #5 clk = ~clk;

    spi_adc_reader #(.WIDTH(12), .LEAD(4), .DIV(DA)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .miso(miso),
        .sclk(sclk), .cs_n(cs_n), .sample(sample), .valid(valid),
        .ready(ready), .busy(busy), .overrun(overrun)
    );

    spi_adc_reader #(.WIDTH(1), .LEAD(0), .DIV(1)) dut_b (
        .clk(clk), .clr_n(clr_n), .start(start_b), .miso(miso_b),
        .sclk(sclk_b), .cs_n(cs_n_b), .sample(sample_b), .valid(valid_b),
        .ready(ready_b), .busy(busy_b), .overrun(overrun_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One frame on the main DUT. mode 0: ready low throughout;
    // mode 1: ready high throughout; mode 2: ready rises on the load edge.
    task automatic do_frame(input string tag, input logic [15:0] word, input int mode);
        int   errs;
        logic pend0;
        logic vexp, sexp, cexp, bexp;
        errs     = 0;
        pend0    = m_pend;
        adc_word = word;
        start    = 1'b1;
        ready    = (mode == 1);
        @(posedge clk);
        for (int k = 0; k <= KA; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            cexp = !(k < LA);
            sexp = (k >= DA) && (k < LA) && (((k - DA) % (2 * DA)) >= DA);
            bexp = (k < KA);
            case (mode)
                0:       vexp = pend0 || (k >= LA);
                1:       vexp = (k == LA);
                default: vexp = (k < LA) ? pend0 : (k == LA);
            endcase
            if (cs_n !== cexp || sclk !== sexp || busy !== bexp || valid !== vexp) errs++;
            if (mode == 2 && k == LA - 1) ready = 1'b1;
        end
        if (mode == 0 && pend0) m_ovr = OVR_EN;
        m_pend = (mode == 0);
        chk({tag, "_wave"}, errs, 0);
        chk({tag, "_sample"}, {20'h0, sample}, {20'h0, word[11:0]});
        chk({tag, "_overrun"}, {31'h0, overrun}, {31'h0, m_ovr});
        ready = 1'b0;
    endtask

    initial begin
        int          errs;
        int          cnt_v, cs_low, run, phase;
        logic [15:0] w;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cs_n", {31'h0, cs_n}, 32'h1);
        chk("rst_sclk", {31'h0, sclk}, 32'h0);
        chk("rst_sample", {20'h0, sample}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Minimal configuration: DIV=1, LEAD=0, WIDTH=1, miso tied high
        errs = 0;
        start_b = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) start_b = 1'b0;
            if (sclk_b !== (k == 2) || valid_b !== (k == 3) ||
                cs_n_b !== !(k < 3) || busy_b !== (k < 4)) errs++;
        end
        chk("b_wave", errs, 0);
        chk("b_sample", {31'h0, sample_b}, 32'h1);

        // Reference frame, consumer always ready
        do_frame("f0abc", 16'h0ABC, 1);

        // Pending sample, ready rises exactly on the next load edge
        do_frame("pend", 16'h5A5A, 0);
        do_frame("load_consume", 16'h1234, 2);

        // Random frames with random ready behaviour
        for (int i = 0; i < 5; i++) begin
            w = 16'($urandom);
            do_frame("rnd", w, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of SHIFT (bit 7, sclk high) with a sample pending
        do_frame("pre_rst", 16'h0F0F, 0);
        adc_word = 16'hBEEF;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= DA + 2 * DA * 7 + DA; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        chk("mid_sclk_high", {31'h0, sclk}, 32'h1);
        clr_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", {31'h0, cs_n}, 32'h1);
        chk("mid_rst_sclk", {31'h0, sclk}, 32'h0);
        chk("mid_rst_valid", {31'h0, valid}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_overrun", {31'h0, overrun}, 32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        repeat (LA + 4) @(negedge clk);
        chk("abort_valid", {31'h0, valid}, 32'h0);
        chk("abort_sample", {20'h0, sample}, 32'h0);
        do_frame("after_rst", 16'h0C3D, 1);

        // Two unread frames back to back
        do_frame("ovr1", 16'h0123, 0);
        do_frame("ovr2", 16'h0FFF, 0);
        chk("ovr_valid", {31'h0, valid}, 32'h1);

        // start held high: back-to-back frames
        w = 16'($urandom);
        adc_word = w;
        ready = 1'b1;
        start = 1'b1;
        cnt_v = 0;
        cs_low = 0;
        run = 0;
        phase = 0;
        @(posedge clk);
        for (int k = 0; k < 2 * (KA + 1); k++) begin
            @(negedge clk);
            if (k == 2 * (KA + 1) - 1) start = 1'b0;
            if (valid) cnt_v++;
            if (!cs_n) cs_low++;
            if (!cs_n) begin
                if (phase == 0) phase = 1;
                else if (phase == 2) phase = 3;
            end else if (phase == 1 || phase == 2) begin
                phase = 2;
                run++;
            end
        end
        errs = 0;
        while (busy && errs < 4 * KA) begin
            @(negedge clk);
            errs++;
        end
        m_pend = 1'b0;
        chk("btb_valid_pulses", cnt_v, 2);
        chk("btb_cs_low_cycles", cs_low, 2 * LA);
        chk("btb_cs_high_gap", run, DA + 1);
        chk("btb_sample", {20'h0, sample}, {20'h0, w[11:0]});
        chk("btb_idle", {31'h0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
